// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped, read-only instruction cache between the IFU and a burst-read
// memory port. Hits answer in the cycle after the request is registered.
// Misses refill a whole line and then answer from the line buffer.
// fence.i clears every valid bit at once.
// Optional feature: define ICACHE_PERF_COUNTER_EN to build the hit/miss
// counters. Without it, perf_hit_o and perf_miss_o are tied to zero.
module ysyx_23060025_icache #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 4,
    parameter int INDEX_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_psel_i,
    input  logic [ADDR_WIDTH-1:0] ifu_paddr_i,
    output logic                  ifu_pready_o,
    output logic [DATA_WIDTH-1:0] ifu_prdata_o,
    input  logic                  fence_i_i,
    output logic                  mem_arvalid_o,
    input  logic                  mem_arready_i,
    output logic [ADDR_WIDTH-1:0] mem_araddr_o,
    output logic [7:0]            mem_arlen_o,
    input  logic                  mem_rvalid_i,
    output logic                  mem_rready_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic [1:0]            mem_rresp_i,
    input  logic                  mem_rlast_i,
    output logic [31:0]           perf_hit_o,
    output logic [31:0]           perf_miss_o
);

    localparam int WORD_W = OFFSET_WIDTH - 2;
    localparam int BEATS  = 1 << WORD_W;
    localparam int LINES  = 1 << INDEX_WIDTH;
    localparam int TAG_W  = ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        ARREQ,
        REFILL,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [TAG_W-1:0]        req_tag_q, req_tag_d;
    logic [INDEX_WIDTH-1:0]  req_index_q, req_index_d;
    logic [WORD_W-1:0]       req_word_q, req_word_d;
    logic [WORD_W-1:0]       beat_q, beat_d;
    logic                    fence_flag_q, fence_flag_d;
    logic                    err_flag_q, err_flag_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [TAG_W-1:0]        tag_d [LINES];
    logic [DATA_WIDTH-1:0]   data_q [LINES][BEATS];
    logic [DATA_WIDTH-1:0]   data_d [LINES][BEATS];
    logic [DATA_WIDTH-1:0]   line_buf_q [BEATS];
    logic [DATA_WIDTH-1:0]   line_buf_d [BEATS];
    logic                    hit;

    // Fetches are word aligned, so the byte-offset bits carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ifu_paddr_i[1:0];

    // A full line is always requested, so the burst length is fixed.
    assign mem_arlen_o = 8'(BEATS - 1);

    // Tag compare uses the valid bits as they stood before any fence this cycle.
    assign hit = valid_q[req_index_q] && (tag_q[req_index_q] == req_tag_q);

    // Next-state logic and the handshake outputs that each state drives.
    always_comb begin
        state_d       = state_q;
        ifu_pready_o  = 1'b0;
        ifu_prdata_o  = '0;
        mem_arvalid_o = 1'b0;
        mem_araddr_o  = '0;
        mem_rready_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ifu_psel_i) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    ifu_pready_o = 1'b1;
                    ifu_prdata_o = data_q[req_index_q][req_word_q];
                    state_d      = IDLE;
                end else begin
                    state_d = ARREQ;
                end
            end
            ARREQ: begin
                mem_arvalid_o = 1'b1;
                mem_araddr_o  = {req_tag_q, req_index_q, {OFFSET_WIDTH{1'b0}}};
                if (mem_arready_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_rready_o = 1'b1;
                if (mem_rvalid_i && mem_rlast_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ifu_pready_o = 1'b1;
                ifu_prdata_o = line_buf_q[req_word_q];
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture, refill bookkeeping and array updates.
    always_comb begin
        req_tag_d    = req_tag_q;
        req_index_d  = req_index_q;
        req_word_d   = req_word_q;
        beat_d       = beat_q;
        fence_flag_d = fence_flag_q;
        err_flag_d   = err_flag_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        line_buf_d   = line_buf_q;

        case (state_q)
            IDLE: begin
                fence_flag_d = 1'b0;
                if (ifu_psel_i) begin
                    req_tag_d   = ifu_paddr_i[ADDR_WIDTH-1 -: TAG_W];
                    req_index_d = ifu_paddr_i[OFFSET_WIDTH +: INDEX_WIDTH];
                    req_word_d  = ifu_paddr_i[2 +: WORD_W];
                end
            end
            ARREQ: begin
                // A fresh miss starts with a clean error record and slot 0.
                beat_d     = '0;
                err_flag_d = 1'b0;
                if (fence_i_i) begin
                    fence_flag_d = 1'b1;
                end
            end
            REFILL: begin
                if (fence_i_i) begin
                    fence_flag_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    line_buf_d[beat_q] = mem_rdata_i;
                    beat_d             = beat_q + WORD_W'(1);
                    if (mem_rresp_i != 2'b00) begin
                        err_flag_d = 1'b1;
                    end
                end
            end
            RESP: begin
                for (int w = 0; w < BEATS; w++) begin
                    data_d[req_index_q][w] = line_buf_q[w];
                end
                tag_d[req_index_q]   = req_tag_q;
                valid_d[req_index_q] = !err_flag_q && !fence_flag_q;
                fence_flag_d         = 1'b0;
                beat_d               = '0;
            end
            default: begin
                fence_flag_d = 1'b0;
            end
        endcase

        // Invalidation wins over any line installed in the same cycle.
        if (fence_i_i) begin
            valid_d = '0;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_tag_q    <= '0;
            req_index_q  <= '0;
            req_word_q   <= '0;
            beat_q       <= '0;
            fence_flag_q <= 1'b0;
            err_flag_q   <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_tag_q    <= req_tag_d;
            req_index_q  <= req_index_d;
            req_word_q   <= req_word_d;
            beat_q       <= beat_d;
            fence_flag_q <= fence_flag_d;
            err_flag_q   <= err_flag_d;
            valid_q      <= valid_d;
        end
    end

    // Storage arrays need no reset: the valid bits guard every read.
    always_ff @(posedge clock) begin
        tag_q      <= tag_d;
        data_q     <= data_d;
        line_buf_q <= line_buf_d;
    end

`ifdef ICACHE_PERF_COUNTER_EN
    logic [31:0] perf_hit_q, perf_hit_d;
    logic [31:0] perf_miss_q, perf_miss_d;

    // Count lookup outcomes; both counters wrap naturally at 2^32.
    always_comb begin
        perf_hit_d  = perf_hit_q;
        perf_miss_d = perf_miss_q;
        if (state_q == LOOKUP) begin
            if (hit) begin
                perf_hit_d = perf_hit_q + 32'd1;
            end else begin
                perf_miss_d = perf_miss_q + 32'd1;
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            perf_hit_q  <= perf_hit_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_hit_o  = perf_hit_q;
    assign perf_miss_o = perf_miss_q;
`else
    assign perf_hit_o  = '0;
    assign perf_miss_o = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Directed testbench for ysyx_23060025_icache. The bench acts as the IFU and
// as a zero-wait (or stalled) burst memory, sampling and driving on the
// falling clock edge. Line contents follow a fixed pattern so that expected
// words can be written down by hand.
module tb_ysyx_23060025_icache;

    logic        clock;
    logic        reset;
    logic        ifu_psel_i;
    logic [31:0] ifu_paddr_i;
    logic        ifu_pready_o;
    logic [31:0] ifu_prdata_o;
    logic        fence_i_i;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic [31:0] mem_araddr_o;
    logic [7:0]  mem_arlen_o;
    logic        mem_rvalid_i;
    logic        mem_rready_o;
    logic [31:0] mem_rdata_i;
    logic [1:0]  mem_rresp_i;
    logic        mem_rlast_i;
    logic [31:0] perf_hit_o;
    logic [31:0] perf_miss_o;

    int checks = 0;
    int errors = 0;

    ysyx_23060025_icache dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_psel_i    (ifu_psel_i),
        .ifu_paddr_i   (ifu_paddr_i),
        .ifu_pready_o  (ifu_pready_o),
        .ifu_prdata_o  (ifu_prdata_o),
        .fence_i_i     (fence_i_i),
        .mem_arvalid_o (mem_arvalid_o),
        .mem_arready_i (mem_arready_i),
        .mem_araddr_o  (mem_araddr_o),
        .mem_arlen_o   (mem_arlen_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rready_o  (mem_rready_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_rresp_i   (mem_rresp_i),
        .mem_rlast_i   (mem_rlast_i),
        .perf_hit_o    (perf_hit_o),
        .perf_miss_o   (perf_miss_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // Memory contents: word i of the line at base B is ((B>>4)<<8) | (i+1)*0x11,
    // truncated to 32 bits. Line 0x3000_0000 therefore holds 0x11..0x44.
    function automatic logic [31:0] line_word(input logic [31:0] base, input int i);
        logic [31:0] t;
        t = base >> 4;
        t = t << 8;
        return t | (32'(i + 1) * 32'h11);
    endfunction

    task automatic check_perf(input string name, input int exp_hit, input int exp_miss);
`ifdef ICACHE_PERF_COUNTER_EN
        check({name, "_hit"}, perf_hit_o, 32'(exp_hit));
        check({name, "_miss"}, perf_miss_o, 32'(exp_miss));
`else
        check({name, "_hit"}, perf_hit_o, 32'(exp_hit) & 32'h0);
        check({name, "_miss"}, perf_miss_o, 32'(exp_miss) & 32'h0);
`endif
    endtask

    // One IFU fetch, with the bench answering memory requests.
    // Starts and ends on a falling edge. exp_lat counts cycles after the
    // request edge (1 = hit). fence_cycle pulses fence.i in that cycle,
    // err_beat flags a beat with SLVERR, reset_beat pulls reset during that beat.
    task automatic fetch(input string name, input logic [31:0] addr,
                         input logic [31:0] exp_data, input int exp_lat,
                         input int ar_stall, input int err_beat,
                         input int fence_cycle, input int reset_beat);
        int          c;
        int          beat;
        int          stall;
        logic        done;
        logic        saw_ar;
        logic [31:0] base;
        logic [31:0] got_data;
        base     = addr & 32'hFFFF_FFF0;
        c        = 0;
        beat     = 0;
        stall    = ar_stall;
        done     = 1'b0;
        saw_ar   = 1'b0;
        got_data = 32'h0;
        ifu_psel_i  = 1'b1;
        ifu_paddr_i = addr;
        while (!done && c < 40) begin
            @(negedge clock);
            c++;
            mem_arready_i = 1'b0;
            mem_rvalid_i  = 1'b0;
            mem_rlast_i   = 1'b0;
            mem_rresp_i   = 2'b00;
            mem_rdata_i   = 32'h0;
            fence_i_i     = (c == fence_cycle);
            if (ifu_pready_o) begin
                got_data = ifu_prdata_o;
                check({name, "_latency"}, 32'(c), 32'(exp_lat));
                check({name, "_data"}, ifu_prdata_o, exp_data);
                ifu_psel_i = 1'b0;
                done       = 1'b1;
            end else if (mem_arvalid_o) begin
                saw_ar = 1'b1;
                check({name, "_araddr"}, mem_araddr_o, base);
                check({name, "_arlen"}, 32'(mem_arlen_o), 32'd3);
                if (stall > 0) begin
                    stall--;
                end else begin
                    mem_arready_i = 1'b1;
                end
            end else if (mem_rready_o) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = line_word(base, beat);
                mem_rlast_i  = (beat == 3);
                mem_rresp_i  = (beat == err_beat) ? 2'b10 : 2'b00;
                if (beat == reset_beat) begin
                    reset      = 1'b0;
                    ifu_psel_i = 1'b0;
                    done       = 1'b1;
                end
                beat++;
            end
        end
        check({name, "_completed"}, 32'(done), 32'd1);
        check({name, "_ar_issued"}, 32'(saw_ar), (exp_lat > 1 || reset_beat >= 0) ? 32'd1 : 32'd0);
        @(negedge clock);
        mem_arready_i = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rlast_i   = 1'b0;
        mem_rresp_i   = 2'b00;
        mem_rdata_i   = 32'h0;
        fence_i_i     = 1'b0;
        if (reset_beat >= 0) begin
            check({name, "_rst_pready"}, 32'(ifu_pready_o), 32'd0);
            check({name, "_rst_arvalid"}, 32'(mem_arvalid_o), 32'd0);
            check({name, "_rst_rready"}, 32'(mem_rready_o), 32'd0);
            check({name, "_rst_araddr"}, mem_araddr_o, 32'h0);
            check({name, "_rst_arlen"}, 32'(mem_arlen_o), 32'd3);
            check_perf({name, "_rst_perf"}, 0, 0);
            reset = 1'b1;
            $display("fetch %s addr=%h aborted by reset", name, addr);
        end else begin
            check({name, "_pready_pulse"}, 32'(ifu_pready_o), 32'd0);
            $display("fetch %s addr=%h data=%h cycles=%0d", name, addr, got_data, c);
        end
    endtask

    initial begin
        reset         = 1'b0;
        ifu_psel_i    = 1'b0;
        ifu_paddr_i   = 32'h0;
        fence_i_i     = 1'b0;
        mem_arready_i = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = 32'h0;
        mem_rresp_i   = 2'b00;
        mem_rlast_i   = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_pready", 32'(ifu_pready_o), 32'd0);
        check("reset_arvalid", 32'(mem_arvalid_o), 32'd0);
        check("reset_rready", 32'(mem_rready_o), 32'd0);
        check("reset_araddr", mem_araddr_o, 32'h0);
        check("reset_arlen", 32'(mem_arlen_o), 32'd3);
        check_perf("reset_perf", 0, 0);
        reset = 1'b1;
        @(negedge clock);

        // Cold miss, then hits in the same line
        fetch("cold_miss", 32'h3000_0004, 32'h0000_0022, 7, 0, -1, -1, -1);
        check_perf("perf_after_miss", 0, 1);
        fetch("hit_word3", 32'h3000_000C, 32'h0000_0044, 1, 0, -1, -1, -1);
        check_perf("perf_after_hit", 1, 1);
        fetch("hit_word2", 32'h3000_0008, 32'h0000_0033, 1, 0, -1, -1, -1);

        // Fence while idle invalidates the line
        fence_i_i = 1'b1;
        @(negedge clock);
        fence_i_i = 1'b0;
        fetch("after_fence", 32'h3000_0000, 32'h0000_0011, 7, 0, -1, -1, -1);
        fetch("refetch_hit", 32'h3000_0000, 32'h0000_0011, 1, 0, -1, -1, -1);

        // Fence during refill: word returned, line left invalid
        fetch("fence_refill", 32'h3000_0044, 32'h0000_0422, 7, 0, -1, 4, -1);
        fetch("fence_remiss", 32'h3000_0044, 32'h0000_0422, 7, 0, -1, -1, -1);
        fetch("fence_rehit", 32'h3000_0044, 32'h0000_0422, 1, 0, -1, -1, -1);

        // Address channel held off for 5 cycles
        fetch("ar_stall", 32'h3000_0088, 32'h0000_0833, 12, 5, -1, -1, -1);
        // Fence alongside a hit: hit still served, line then gone
        fetch("fence_on_hit", 32'h3000_0088, 32'h0000_0833, 1, 0, -1, 1, -1);
        fetch("after_hit_fence", 32'h3000_0088, 32'h0000_0833, 7, 0, -1, -1, -1);

        // Error response on beat 1
        fetch("err_beat", 32'h3000_00C0, 32'h0000_0C11, 7, 0, 1, -1, -1);
        fetch("err_remiss", 32'h3000_00C0, 32'h0000_0C11, 7, 0, -1, -1, -1);
        fetch("err_rehit", 32'h3000_00C0, 32'h0000_0C11, 1, 0, -1, -1, -1);

        // Same index, different tag evicts the old line
        fetch("conflict_a", 32'h4000_0008, 32'h0000_0033, 7, 0, -1, -1, -1);
        fetch("conflict_b", 32'h3000_0004, 32'h0000_0022, 7, 0, -1, -1, -1);
        check_perf("perf_before_rst", 6, 10);

        // Reset during beat 2 of a refill
        fetch("rst_refill", 32'h3000_0050, 32'h0000_0511, 7, 0, -1, -1, 2);
        fetch("rst_remiss", 32'h3000_0050, 32'h0000_0511, 7, 0, -1, -1, -1);
        fetch("rst_rehit", 32'h3000_0050, 32'h0000_0511, 1, 0, -1, -1, -1);
        check_perf("perf_after_rst", 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
